// File: rtl/rv32_single_cycle_core.sv
// Single-cycle RV32I-subset core: PC, register file, ALU, immediate generator and branch unit.
// Instruction and data memories are external and read combinationally.

module rv32_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            rd_we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_wdata
);
  logic [XLEN-1:0] rw_reg [0:31];

  // Flop array rather than RAM: every register clears on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rw_reg[i] <= '0;
    end else if (rd_we && (rd_addr != 5'd0)) begin
      rw_reg[rd_addr] <= rd_wdata;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : rw_reg[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : rw_reg[rs2_addr];
endmodule

module rv32_single_cycle_core #(
  parameter int          XLEN     = 32,
  parameter int          IM_AW    = 10,
  parameter int          DM_AW    = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  output logic             IM_read,
  output logic             IM_enable,
  output logic [IM_AW-1:0] IM_address,
  input  logic [XLEN-1:0]  DM_out,
  output logic             DM_read,
  output logic             DM_write,
  output logic             DM_enable,
  output logic [DM_AW-1:0] DM_address,
  output logic [XLEN-1:0]  DM_in
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [XLEN-1:0] pc_reg, pc_next, pc_plus4, jalr_sum;
  logic [6:0]      opcode;
  logic [4:0]      rd_addr, rs1_addr, rs2_addr, shamt;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
  logic [DM_AW+1:0] mem_imm;
  logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_result, rd_wdata;
  logic            rd_we, dm_rd, dm_wr, branch_taken, ea_carry;
  logic [DM_AW-1:0] dm_word;

  assign opcode   = instruction[6:0];
  assign rd_addr  = instruction[11:7];
  assign funct3   = instruction[14:12];
  assign rs1_addr = instruction[19:15];
  assign rs2_addr = instruction[24:20];

  assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
  assign imm_b = {{(XLEN-12){instruction[31]}}, instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{(XLEN-20){instruction[31]}}, instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};

  rv32_regfile #(.XLEN(XLEN)) regfile1 (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .rd_we    (rd_we & rst),
    .rd_addr  (rd_addr),
    .rd_wdata (rd_wdata)
  );

  assign pc_plus4 = pc_reg + XLEN'(4);
  assign jalr_sum = rs1_val + imm_i;

  // Only address bits [DM_AW+1:2] matter; the carry out of bits [1:0] is kept explicitly.
  assign mem_imm  = (opcode == OPC_STORE)
                  ? {{(DM_AW-10){instruction[31]}}, instruction[31:25], instruction[11:7]}
                  : imm_i[DM_AW+1:0];
  assign ea_carry = (rs1_val[1] & mem_imm[1]) |
                    ((rs1_val[1] | mem_imm[1]) & rs1_val[0] & mem_imm[0]);
  assign dm_word  = rs1_val[DM_AW+1:2] + mem_imm[DM_AW+1:2] + {{(DM_AW-1){1'b0}}, ea_carry};

  always_comb begin
    alu_b      = (opcode == OPC_OP) ? rs2_val : imm_i;
    shamt      = alu_b[4:0];
    alu_result = '0;
    case (funct3)
      3'b000: alu_result = (opcode == OPC_OP && instruction[30]) ? rs1_val - alu_b
                                                                  : rs1_val + alu_b;
      3'b001: alu_result = rs1_val << shamt;
      3'b010: alu_result = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_result = {{(XLEN-1){1'b0}}, rs1_val < alu_b};
      3'b100: alu_result = rs1_val ^ alu_b;
      3'b101: alu_result = instruction[30] ? $unsigned($signed(rs1_val) >>> shamt)
                                           : rs1_val >> shamt;
      3'b110: alu_result = rs1_val | alu_b;
      default: alu_result = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = (rs1_val == rs2_val);
      3'b001:  branch_taken = (rs1_val != rs2_val);
      3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  branch_taken = (rs1_val <  rs2_val);
      3'b111:  branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  // Decode: anything unrecognised falls through as a NOP (PC+4, no side effects).
  always_comb begin
    rd_we    = 1'b0;
    rd_wdata = alu_result;
    pc_next  = pc_plus4;
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    case (opcode)
      OPC_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
      OPC_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_reg + imm_u; end
      OPC_JAL:   begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_next = pc_reg + imm_j; end
      OPC_JALR:
        if (funct3 == 3'b000) begin
          rd_we    = 1'b1;
          rd_wdata = pc_plus4;
          pc_next  = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
        end
      OPC_BRANCH: if (branch_taken) pc_next = pc_reg + imm_b;
      OPC_LOAD:
        if (funct3 == 3'b010) begin
          rd_we    = 1'b1;
          dm_rd    = 1'b1;
          rd_wdata = DM_out;
        end
      OPC_STORE: if (funct3 == 3'b010) dm_wr = 1'b1;
      OPC_OPIMM: rd_we = 1'b1;
      OPC_OP:    rd_we = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) pc_reg <= RESET_PC[XLEN-1:0];
    else      pc_reg <= pc_next;
  end

  assign IM_read    = 1'b1;
  assign IM_enable  = 1'b1;
  assign IM_address = pc_reg[IM_AW-1:0];
  assign DM_read    = rst & dm_rd;
  assign DM_write   = rst & dm_wr;
  assign DM_enable  = rst & (dm_rd | dm_wr);
  assign DM_address = rst ? dm_word : '0;
  assign DM_in      = rst ? rs2_val : '0;
endmodule

// File: tb/tb_rv32_single_cycle_core.sv
// Directed bench for rv32_single_cycle_core: small hand-assembled programs with
// hand-computed register, memory and PC results.

module tb_rv32_single_cycle_core;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction;
  logic        IM_read, IM_enable, DM_read, DM_write, DM_enable;
  logic [9:0]  IM_address;
  logic [11:0] DM_address;
  logic [31:0] DM_out, DM_in;

  logic [31:0] im_mem [0:255];
  logic [31:0] dm_mem [0:4095];
  int          wr_count = 0;
  int          wr_base;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rv32_single_cycle_core dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .IM_read     (IM_read),
    .IM_enable   (IM_enable),
    .IM_address  (IM_address),
    .DM_out      (DM_out),
    .DM_read     (DM_read),
    .DM_write    (DM_write),
    .DM_enable   (DM_enable),
    .DM_address  (DM_address),
    .DM_in       (DM_in)
  );

  assign instruction = im_mem[IM_address[9:2]];
  assign DM_out      = dm_mem[DM_address];

  always @(posedge clk) begin
    if (DM_write) begin
      dm_mem[DM_address] <= DM_in;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("check %s got=%08h ok", tag, got);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                        logic [31:0] rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                        logic [31:0] f3, logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP_REG};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                        logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OP_JAL};
  endfunction
  function automatic logic [31:0] enc_u(logic [31:0] imm20, logic [31:0] rd, logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction

  // Enter reset and fill IM with NOPs; the caller then loads its program.
  task automatic start_program();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) im_mem[i] = 32'h0000_0000;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Program A: arithmetic, x0 write, LUI/AUIPC
    start_program();
    im_mem[0] = enc_i(5, 0, 0, 1, OP_IMM);
    im_mem[1] = enc_i(-3, 0, 0, 2, OP_IMM);
    im_mem[2] = enc_r(0, 2, 1, 0, 3);
    im_mem[3] = enc_r(7'h20, 2, 1, 0, 4);
    im_mem[4] = enc_i(9, 0, 0, 0, OP_IMM);
    im_mem[5] = enc_u(32'h12345, 8, OP_LUI);
    im_mem[6] = enc_u(32'h00001, 9, OP_AUIPC);
    repeat (2) @(negedge clk);
    check_value("rst_im_addr", {22'd0, IM_address}, 32'h0);
    check_value("rst_im_strobes", {30'd0, IM_read, IM_enable}, 32'h3);
    check_value("rst_dm_strobes", {29'd0, DM_read, DM_write, DM_enable}, 32'h0);
    check_value("rst_dm_addr", {20'd0, DM_address}, 32'h0);
    check_value("rst_dm_in", DM_in, 32'h0);
    check_value("rst_x1", dut.regfile1.rw_reg[1], 32'h0);
    release_reset();
    run_cycles(7);
    check_value("add_x3", dut.regfile1.rw_reg[3], 32'd2);
    check_value("sub_x4", dut.regfile1.rw_reg[4], 32'd8);
    check_value("x0_stays_0", dut.regfile1.rw_reg[0], 32'h0);
    check_value("lui_x8", dut.regfile1.rw_reg[8], 32'h1234_5000);
    check_value("auipc_x9", dut.regfile1.rw_reg[9], 32'h0000_1018);
    check_value("pc_after_A", {22'd0, IM_address}, 32'h1C);

    // Program B: store then load through DM
    start_program();
    im_mem[0] = enc_i(7, 0, 0, 1, OP_IMM);
    im_mem[1] = enc_s(8, 1, 0);
    im_mem[2] = enc_i(8, 0, 2, 5, OP_LOAD);
    release_reset();
    wr_base = wr_count;
    run_cycles(1);
    check_value("sw_strobes", {29'd0, DM_read, DM_write, DM_enable}, 32'h3);
    check_value("sw_dm_addr", {20'd0, DM_address}, 32'h2);
    check_value("sw_dm_in", DM_in, 32'd7);
    run_cycles(1);
    check_value("lw_strobes", {29'd0, DM_read, DM_write, DM_enable}, 32'h5);
    check_value("lw_dm_addr", {20'd0, DM_address}, 32'h2);
    run_cycles(1);
    check_value("dm_word2", dm_mem[2], 32'd7);
    check_value("lw_x5", dut.regfile1.rw_reg[5], 32'd7);
    check_value("sw_pulses", wr_count - wr_base, 32'd1);
    check_value("nop_strobes", {29'd0, DM_read, DM_write, DM_enable}, 32'h0);

    // Program C: compares, shifts, logic immediates
    start_program();
    im_mem[0]  = enc_i(-1, 0, 0, 1, OP_IMM);
    im_mem[1]  = enc_i(1, 0, 0, 2, OP_IMM);
    im_mem[2]  = enc_r(0, 2, 1, 2, 3);
    im_mem[3]  = enc_r(0, 2, 1, 3, 4);
    im_mem[4]  = enc_i(32'h404, 1, 5, 5, OP_IMM);
    im_mem[5]  = enc_i(28, 1, 5, 6, OP_IMM);
    im_mem[6]  = enc_i(31, 2, 1, 7, OP_IMM);
    im_mem[7]  = enc_i(32'h0F0, 1, 4, 8, OP_IMM);
    im_mem[8]  = enc_i(32'h0AB, 1, 7, 9, OP_IMM);
    im_mem[9]  = enc_i(-16, 0, 6, 10, OP_IMM);
    im_mem[10] = enc_i(-1, 2, 3, 11, OP_IMM);
    im_mem[11] = enc_i(0, 1, 2, 12, OP_IMM);
    im_mem[12] = enc_r(7'h20, 2, 7, 5, 13);
    im_mem[13] = enc_r(0, 2, 7, 5, 14);
    im_mem[14] = enc_r(0, 9, 8, 7, 15);
    release_reset();
    run_cycles(15);
    check_value("slt_x3", dut.regfile1.rw_reg[3], 32'd1);
    check_value("sltu_x4", dut.regfile1.rw_reg[4], 32'd0);
    check_value("srai_x5", dut.regfile1.rw_reg[5], 32'hFFFF_FFFF);
    check_value("srli_x6", dut.regfile1.rw_reg[6], 32'd15);
    check_value("slli_x7", dut.regfile1.rw_reg[7], 32'h8000_0000);
    check_value("xori_x8", dut.regfile1.rw_reg[8], 32'hFFFF_FF0F);
    check_value("andi_x9", dut.regfile1.rw_reg[9], 32'h0000_00AB);
    check_value("ori_x10", dut.regfile1.rw_reg[10], 32'hFFFF_FFF0);
    check_value("sltiu_x11", dut.regfile1.rw_reg[11], 32'd1);
    check_value("slti_x12", dut.regfile1.rw_reg[12], 32'd1);
    check_value("sra_x13", dut.regfile1.rw_reg[13], 32'hC000_0000);
    check_value("srl_x14", dut.regfile1.rw_reg[14], 32'h4000_0000);
    check_value("and_x15", dut.regfile1.rw_reg[15], 32'h0000_000B);

    // Program D: branches and jumps
    start_program();
    im_mem[0]  = enc_b(8, 0, 0, 0);            // 0x00 BEQ x0,x0,+8
    im_mem[1]  = enc_i(1, 0, 0, 1, OP_IMM);    // 0x04 skipped
    im_mem[2]  = enc_b(8, 0, 0, 1);            // 0x08 BNE not taken
    im_mem[3]  = enc_i(2, 0, 0, 2, OP_IMM);    // 0x0C
    im_mem[4]  = enc_j(16, 3);                 // 0x10 JAL x3,+16
    im_mem[5]  = enc_i(4, 0, 0, 4, OP_IMM);    // 0x14
    im_mem[6]  = enc_i(-1, 0, 0, 5, OP_IMM);   // 0x18
    im_mem[7]  = enc_b(8, 0, 5, 4);            // 0x1C BLT x5,x0 taken
    im_mem[8]  = enc_i(0, 3, 0, 0, OP_JALR);   // 0x20 JALR x0,0(x3)
    im_mem[9]  = enc_b(8, 0, 5, 6);            // 0x24 BLTU not taken
    im_mem[10] = enc_b(8, 0, 5, 7);            // 0x28 BGEU taken
    im_mem[11] = enc_i(6, 0, 0, 6, OP_IMM);    // 0x2C skipped
    im_mem[12] = enc_b(8, 5, 0, 5);            // 0x30 BGE x0,x5 taken
    im_mem[13] = enc_i(7, 0, 0, 7, OP_IMM);    // 0x34 skipped
    im_mem[14] = enc_i(32'h2D, 3, 0, 3, OP_JALR); // 0x38 JALR x3,0x2D(x3)
    im_mem[15] = enc_i(9, 0, 0, 9, OP_IMM);    // 0x3C skipped
    im_mem[16] = enc_i(10, 0, 0, 10, OP_IMM);  // 0x40
    release_reset();
    run_cycles(4);
    check_value("jal_link_x3", dut.regfile1.rw_reg[3], 32'h14);
    check_value("jal_target", {22'd0, IM_address}, 32'h20);
    run_cycles(1);
    check_value("jalr_target", {22'd0, IM_address}, 32'h14);
    run_cycles(8);
    check_value("beq_skip_x1", dut.regfile1.rw_reg[1], 32'd0);
    check_value("bne_fall_x2", dut.regfile1.rw_reg[2], 32'd2);
    check_value("after_ret_x4", dut.regfile1.rw_reg[4], 32'd4);
    check_value("bgeu_skip_x6", dut.regfile1.rw_reg[6], 32'd0);
    check_value("bge_skip_x7", dut.regfile1.rw_reg[7], 32'd0);
    check_value("jalr_skip_x9", dut.regfile1.rw_reg[9], 32'd0);
    check_value("jalr_rd_rs1_x3", dut.regfile1.rw_reg[3], 32'h3C);
    check_value("final_x10", dut.regfile1.rw_reg[10], 32'd10);
    check_value("pc_after_D", {22'd0, IM_address}, 32'h44);

    // Mid-program reset
    rst = 1'b0;
    run_cycles(1);
    check_value("midrst_pc", {22'd0, IM_address}, 32'h0);
    check_value("midrst_x3", dut.regfile1.rw_reg[3], 32'h0);
    check_value("midrst_x10", dut.regfile1.rw_reg[10], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
